// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory sequencer: default widths
// and the externally visible state encoding.
package imem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

endpackage

// File: rtl/imem_sequencer.sv
// Owns the single port of the instruction memory: fills it from a byte
// stream, then fetches instructions to the decoder with jump/halt control.
module imem_sequencer
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_start,
    input  logic              halt,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   load_count,
    output logic [1:0]        state_o,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              wr_fire_s;

    // Next-state: priority load_start > halt > jump_en > run_start > fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_pc_d       = rd_pc_q;
        instr_pc_d    = instr_pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        inflight_d    = inflight_q;
        load_count_d  = load_count_q;
        wr_fire_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = PTR_ZERO;
                    load_count_d = CNT_ZERO;
                end else if (run_start) begin
                    state_d = ST_RUN;
                    pc_d    = PTR_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    wr_ptr_d     = PTR_ZERO;
                    load_count_d = CNT_ZERO;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else if (load_valid) begin
                    wr_fire_s    = 1'b1;
                    wr_ptr_d     = wr_ptr_q + PTR_ONE;
                    load_count_d = load_count_q + CNT_ONE;
                    if (load_last || (wr_ptr_q == PTR_LAST)) begin
                        state_d       = ST_RUN;
                        pc_d          = PTR_ZERO;
                        instr_valid_d = 1'b0;
                        inflight_d    = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d       = ST_LOAD;
                    wr_ptr_d      = PTR_ZERO;
                    load_count_d  = CNT_ZERO;
                    instr_valid_d = 1'b0;
                    inflight_d    = 1'b0;
                end else if (halt) begin
                    state_d       = ST_HALT;
                    instr_valid_d = 1'b0;
                    inflight_d    = 1'b0;
                end else if (jump_en) begin
                    // Any read issued or in flight now is dropped.
                    pc_d          = jump_addr;
                    instr_valid_d = 1'b0;
                    inflight_d    = 1'b0;
                end else if (inflight_q) begin
                    instr_d       = mem_rdata;
                    instr_pc_d    = rd_pc_q;
                    instr_valid_d = 1'b1;
                    inflight_d    = 1'b0;
                end else if (!instr_valid_q || instr_ready) begin
                    instr_valid_d = 1'b0;
                    inflight_d    = 1'b1;
                    rd_pc_d       = pc_q;
                    pc_d          = pc_q + PTR_ONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = PTR_ZERO;
                    load_count_d = CNT_ZERO;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= PTR_ZERO;
            wr_ptr_q      <= PTR_ZERO;
            rd_pc_q       <= PTR_ZERO;
            instr_pc_q    <= PTR_ZERO;
            instr_q       <= {DATA_W{1'b0}};
            instr_valid_q <= 1'b0;
            inflight_q    <= 1'b0;
            load_count_q  <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_pc_q       <= rd_pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            inflight_q    <= inflight_d;
            load_count_q  <= load_count_d;
        end
    end

    // The memory port is steered by the loader in LOAD, by the pc otherwise.
    assign load_ready  = (state_q == ST_LOAD);
    assign mem_we      = wr_fire_s;
    assign mem_addr    = (state_q == ST_LOAD) ? wr_ptr_q : pc_q;
    assign mem_wdata   = wr_fire_s ? load_data : {DATA_W{1'b0}};
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign load_count  = load_count_q;
    assign state_o     = state_q;

endmodule

// File: doc/imem_sequencer.md
# imem_sequencer

Controller that owns the 16×8 instruction memory and shares its single port between two requesters: a byte-serial program loader and the instruction fetch path. It fills the memory from a valid/ready byte stream, then sequences the program counter, issues reads, and delivers instructions to the decoder over a valid/ready handshake with jump and halt control. It sits between the top-level program-load interface, the memory array, and the decode stage.

## Interface
- ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, instruction width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- load_start  in  1  pulse: begin (or restart) program load at address 0
- load_valid  in  1  load byte present
- load_data  in  DATA_W  load byte
- load_last  in  1  qualifies final load byte
- load_ready  out  1  sequencer accepts load byte this cycle
- run_start  in  1  pulse: enter RUN at pc 0 without loading
- halt  in  1  pulse: stop fetching
- jump_en  in  1  redirect pc
- jump_addr  in  ADDR_W  redirect target
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr valid
- instr_ready  in  1  decoder consumes instr
- pc  out  ADDR_W  next fetch address
- load_count  out  ADDR_W+1  bytes written in last load (0..16)
- state_o  out  2  current state encoding
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address (shared read/write)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after read issue

## Operation
- States: IDLE=0, LOAD=1, RUN=2, HALT=3.
- IDLE: load_start→LOAD; run_start→RUN. Other inputs ignored.
- LOAD: load_ready=1. Each load_valid&load_ready writes load_data at wr_ptr (mem_we=1, mem_addr=wr_ptr), then wr_ptr and load_count increment. On load_last, or on the 16th byte, go to RUN with pc=0. load_start mid-load restarts the load: wr_ptr=0, load_count=0.
- RUN: a read is issued (mem_addr=pc, mem_we=0) when no read is in flight and (!instr_valid | instr_ready). Next cycle, instr<=mem_rdata, instr_pc<=issued pc, instr_valid=1. pc increments modulo 16 at issue (15→0).
- jump_en in RUN: the in-flight read is discarded, instr_valid is cleared, and pc<=jump_addr. The next issue is at jump_addr.
- halt in RUN or LOAD goes to HALT. It clears instr_valid and any in-flight read. pc is held. In HALT, run_start resumes RUN at the held pc, and load_start enters LOAD.
- load_start in RUN or HALT goes to LOAD. It flushes the fetch state and clears load_count.
- Priority within one cycle: load_start > halt > jump_en > run_start > normal fetch.
- Outside LOAD: load_ready=0, mem_we=0. Outside RUN: no reads are issued.

## Timing
- Reset values: state IDLE; pc 0; instr 0; instr_pc 0; instr_valid 0; load_ready 0; load_count 0; mem_we 0; mem_addr 0; mem_wdata 0.
- Load: one byte per cycle while load_valid is high. The last byte write and the LOAD→RUN transition occur on the same edge. The first read issues in the first RUN cycle.
- Fetch latency: read issued in cycle N gives instr_valid in N+1.
- Throughput: one instruction per 2 cycles with instr_ready held high.
- instr, instr_pc and instr_valid are held stable while instr_valid & !instr_ready.
- jump_en takes effect on the asserting edge. A read issued in the same cycle as jump_en is not counted and never reaches instr.
- Reset asserted mid-operation returns all outputs to reset values immediately. Memory contents are not cleared.

## Structure
- Shared package `imem_pkg`: state encoding constants (ST_IDLE..ST_HALT), ADDR_W/DATA_W defaults, DEPTH.
- Single module. The memory array is external and connects via mem_* ports; the existing instruction memory is wrapped to a registered read of one-cycle latency.
- No sub-module required. The fetch issue/in-flight/output-register logic may be split as `imem_fetch_stage` if convenient.

## Test plan
- Reset mid-LOAD after 3 bytes → state 0, load_ready 0, load_count 0, pc 0 during and after reset.
- load_start; bytes 0x11,0x22,0x33 with load_last on 0x33 → writes at addr 0,1,2; load_count=3; RUN; instr sequence 0x11,0x22,0x33 with instr_pc 0,1,2.
- Load 16 bytes without load_last → auto RUN after 16th byte; load_count=16; fetch wraps: instr_pc 15 followed by instr_pc 0.
- RUN with instr_ready low for 5 cycles → instr/instr_pc held, no further read issued, pc unchanged; then ready high → sequence continues without loss or duplication.
- jump_en to addr 9 while a read of addr 4 is in flight → addr 4 never appears; next instr_pc=9.
- halt at pc 6, then run_start → first instr_pc=6. Same-cycle load_start+halt+jump_en → state LOAD, load_count 0.
